// File: rtl/pipe_flow_ctrl_if.sv
// Pipeline-control bundle: hazard/MDU/M-stage status from the datapath, stage strobes back.
// The datapath side is the master; the flow controller is the slave.
interface pipe_flow_ctrl_if;
    logic D_hazard;
    logic D_is_md;
    logic E_md_start;
    logic E_md_is_div;
    logic M_valid;
    logic M_exc;
    logic M_eret;
    logic irq;

    logic F_en;
    logic D_en;
    logic E_bubble;
    logic req;
    logic eret_flush;
    logic md_busy;
    logic irq_pend;

    modport master (
        output D_hazard, D_is_md, E_md_start, E_md_is_div, M_valid, M_exc, M_eret, irq,
        input  F_en, D_en, E_bubble, req, eret_flush, md_busy, irq_pend
    );

    modport slave (
        input  D_hazard, D_is_md, E_md_start, E_md_is_div, M_valid, M_exc, M_eret, irq,
        output F_en, D_en, E_bubble, req, eret_flush, md_busy, irq_pend
    );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Stall/flush/exception sequencer for the five-stage pipeline: MDU busy countdown,
// pending-interrupt latch and the per-stage enable/bubble/flush strobes.
module pipe_flow_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input logic             clk,
    input logic             reset,
    pipe_flow_ctrl_if.slave ctrl_io
);

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDiv
    } md_state_e;

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_pend_q, irq_pend_d;

    logic req;
    logic start_ok;
    logic stall;

    // An interrupt already latched or arriving this cycle is taken by the first real M instruction.
    assign req      = ctrl_io.M_valid & (ctrl_io.M_exc | irq_pend_q | ctrl_io.irq);
    // An instruction being flushed must not launch the MDU.
    assign start_ok = ctrl_io.E_md_start & ~req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    if (ctrl_io.E_md_is_div) begin
                        state_d = StDiv;
                        cnt_d   = CNT_W'(DIV_CYC);
                    end else begin
                        state_d = StMult;
                        cnt_d   = CNT_W'(MULT_CYC);
                    end
                end
            end
            StMult, StDiv: begin
                // Keeps counting through a flush so HI/LO still complete.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        irq_pend_d = irq_pend_q;
        if (req) begin
            irq_pend_d = 1'b0;
        end else if (ctrl_io.irq && !irq_pend_q) begin
            irq_pend_d = 1'b1;
        end
    end

    always_comb begin
        ctrl_io.md_busy    = start_ok | (cnt_q != '0);
        stall              = ctrl_io.D_hazard | (ctrl_io.D_is_md & ctrl_io.md_busy);
        ctrl_io.req        = req;
        ctrl_io.irq_pend   = irq_pend_q;
        ctrl_io.eret_flush = ctrl_io.M_eret & ctrl_io.M_valid & ~req;
        ctrl_io.F_en       = ~stall;
        ctrl_io.D_en       = ~stall;
        ctrl_io.E_bubble   = stall;
        // Flush wins over stall: everything advances, D/E gets a NOP.
        if (req) begin
            ctrl_io.F_en     = 1'b1;
            ctrl_io.D_en     = 1'b1;
            ctrl_io.E_bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: MDU countdown, stalls, IRQ latch, flush and eret paths.
module tb_pipe_flow_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    pipe_flow_ctrl_if bus ();

    pipe_flow_ctrl #(
        .MULT_CYC(5),
        .DIV_CYC (10),
        .CNT_W   (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ctrl_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A new MDU start while a countdown is running must never be presented.
    always @(posedge clk) begin
        if (!reset && bus.E_md_start && !bus.req && dut.cnt_q != '0) begin
            $error("MDU start while busy");
        end
    end

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.D_hazard    = 1'b0;
        bus.D_is_md     = 1'b0;
        bus.E_md_start  = 1'b0;
        bus.E_md_is_div = 1'b0;
        bus.M_valid     = 1'b0;
        bus.M_exc       = 1'b0;
        bus.M_eret      = 1'b0;
        bus.irq         = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset = 1'b1;
        bus.irq = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        bus.irq = 1'b0;
        #1;
        check("rst_f_en", bus.F_en, 1'b1);
        check("rst_d_en", bus.D_en, 1'b1);
        check("rst_bubble", bus.E_bubble, 1'b0);
        check("rst_req", bus.req, 1'b0);
        check("rst_eret", bus.eret_flush, 1'b0);
        check("rst_busy", bus.md_busy, 1'b0);
        check("rst_irq_pend", bus.irq_pend, 1'b0);

        // mult: busy on start cycle plus 5
        bus.E_md_start = 1'b1;
        #1;
        check("mult_busy_start", bus.md_busy, 1'b1);
        tick();
        bus.E_md_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("mult_busy_cnt", bus.md_busy, 1'b1);
            check("mult_no_stall", bus.F_en, 1'b1);
            tick();
        end
        check("mult_done", bus.md_busy, 1'b0);

        // div then MDU-using D instruction: 10 stall cycles
        bus.E_md_start  = 1'b1;
        bus.E_md_is_div = 1'b1;
        #1;
        check("div_busy_start", bus.md_busy, 1'b1);
        check("div_start_no_stall", bus.F_en, 1'b1);
        tick();
        bus.E_md_start  = 1'b0;
        bus.E_md_is_div = 1'b0;
        bus.D_is_md     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("div_stall_f_en", bus.F_en, 1'b0);
            check("div_stall_d_en", bus.D_en, 1'b0);
            check("div_stall_bubble", bus.E_bubble, 1'b1);
            tick();
        end
        check("div_release_f_en", bus.F_en, 1'b1);
        check("div_release_bubble", bus.E_bubble, 1'b0);
        check("div_release_busy", bus.md_busy, 1'b0);
        bus.D_is_md = 1'b0;

        // single-cycle load-use hazard
        bus.D_hazard = 1'b1;
        #1;
        check("haz_f_en", bus.F_en, 1'b0);
        check("haz_d_en", bus.D_en, 1'b0);
        check("haz_bubble", bus.E_bubble, 1'b1);
        tick();
        bus.D_hazard = 1'b0;
        #1;
        check("haz_clear_f_en", bus.F_en, 1'b1);
        check("haz_clear_bubble", bus.E_bubble, 1'b0);

        // irq arriving over bubbles in M is held until a valid M
        bus.irq = 1'b1;
        #1;
        check("irq_bubble_req", bus.req, 1'b0);
        tick();
        check("irq_latched", bus.irq_pend, 1'b1);
        check("irq_bubble_req2", bus.req, 1'b0);
        tick();
        tick();
        bus.irq     = 1'b0;
        bus.M_valid = 1'b1;
        #1;
        check("irq_take_req", bus.req, 1'b1);
        check("irq_take_pend", bus.irq_pend, 1'b1);
        check("irq_take_f_en", bus.F_en, 1'b1);
        check("irq_take_d_en", bus.D_en, 1'b1);
        check("irq_take_bubble", bus.E_bubble, 1'b1);
        tick();
        check("irq_cleared", bus.irq_pend, 1'b0);
        check("irq_no_req", bus.req, 1'b0);
        bus.M_valid = 1'b0;

        // flushed instruction never starts the MDU
        bus.E_md_start = 1'b1;
        bus.M_exc      = 1'b1;
        bus.M_valid    = 1'b1;
        #1;
        check("exc_req", bus.req, 1'b1);
        check("exc_blocks_start", bus.md_busy, 1'b0);
        tick();
        idle_inputs();
        bus.D_is_md = 1'b1;
        #1;
        check("exc_fsm_idle", bus.md_busy, 1'b0);
        check("exc_no_md_stall", bus.F_en, 1'b1);
        bus.D_is_md = 1'b0;

        // eret path, and eret with exception goes through req
        bus.M_eret  = 1'b1;
        bus.M_valid = 1'b1;
        #1;
        check("eret_flush", bus.eret_flush, 1'b1);
        check("eret_no_req", bus.req, 1'b0);
        bus.M_exc = 1'b1;
        #1;
        check("eret_exc_req", bus.req, 1'b1);
        check("eret_exc_flush", bus.eret_flush, 1'b0);
        bus.M_exc   = 1'b0;
        bus.M_valid = 1'b0;
        #1;
        check("eret_bubble", bus.eret_flush, 1'b0);
        bus.M_eret = 1'b0;

        // req dominates a D hazard
        bus.D_hazard = 1'b1;
        bus.M_exc    = 1'b1;
        bus.M_valid  = 1'b1;
        #1;
        check("dom_f_en", bus.F_en, 1'b1);
        check("dom_d_en", bus.D_en, 1'b1);
        check("dom_bubble", bus.E_bubble, 1'b1);
        tick();
        idle_inputs();

        // running mult keeps counting through a flush
        bus.E_md_start = 1'b1;
        tick();
        bus.E_md_start = 1'b0;
        bus.M_exc      = 1'b1;
        bus.M_valid    = 1'b1;
        #1;
        check("flush_busy", bus.md_busy, 1'b1);
        tick();
        bus.M_exc   = 1'b0;
        bus.M_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("flush_busy_last", bus.md_busy, 1'b1);
        tick();
        check("flush_busy_done", bus.md_busy, 1'b0);

        // reset mid-divide clears the countdown
        bus.E_md_start  = 1'b1;
        bus.E_md_is_div = 1'b1;
        tick();
        bus.E_md_start  = 1'b0;
        bus.E_md_is_div = 1'b0;
        tick();
        check("pre_reset_busy", bus.md_busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("post_reset_busy", bus.md_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
